// File: rtl/fpga_nn_pkg.sv
// Shared types and Q3.5 helpers for the fully-connected layer datapath.
package fpga_nn_pkg;

  localparam int DW        = 8;
  localparam int FRAC_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    WRITE,
    FIN
  } state_e;

  // Counter/address width that stays at least one bit for degenerate sizes.
  function automatic int clog2g(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
    return x[DW-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/relu_q35.sv
// Combinational ReLU on a signed fixed-point word: negatives clamp to zero.
module relu_q35 #(
  parameter int DW = fpga_nn_pkg::DW
) (
  input  logic [DW-1:0] x,
  output logic [DW-1:0] y
);

  assign y = x[DW-1] ? '0 : x;

endmodule

// File: rtl/forprop_layer_ctrl.sv
// Tile sequencer for one fully-connected layer: clear, stream N_IN
// input/weight pairs into N_PAR neurons, then write ReLU'd results.
module forprop_layer_ctrl
  import fpga_nn_pkg::*;
#(
  parameter int N_IN   = 16,
  parameter int N_OUT  = 4,
  parameter int N_PAR  = 2,
  parameter int DW     = fpga_nn_pkg::DW,
  parameter int IN_AW  = clog2g(N_IN),
  parameter int W_AW   = clog2g(N_IN*N_OUT/N_PAR),
  parameter int OUT_AW = clog2g(N_OUT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [IN_AW-1:0]    in_addr,
  output logic [W_AW-1:0]     w_addr,
  output logic                neuron_clear,
  output logic                neuron_en,
  input  logic [N_PAR*DW-1:0] accum,
  output logic                out_we,
  output logic [OUT_AW-1:0]   out_addr,
  output logic [DW-1:0]       out_data
);

  localparam int N_TILES = N_OUT / N_PAR;
  localparam int TW      = clog2g(N_TILES);
  localparam int KW      = clog2g(N_PAR);

  state_e                   state, state_nx;
  logic [IN_AW-1:0]         idx;
  logic [TW-1:0]            tile;
  logic [KW-1:0]            k;
  logic [N_PAR-1:0][DW-1:0] lane_relu;

  logic idx_last, k_last, tile_last;
  assign idx_last  = (idx == IN_AW'(N_IN-1));
  assign k_last    = (k == KW'(N_PAR-1));
  assign tile_last = (tile == TW'(N_TILES-1));

  for (genvar g = 0; g < N_PAR; g++) begin : g_lane
    relu_q35 #(.DW(DW)) u_relu (
      .x (accum[g*DW +: DW]),
      .y (lane_relu[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    done         = 1'b0;
    neuron_clear = 1'b0;
    in_addr      = '0;
    w_addr       = '0;
    out_we       = 1'b0;
    out_addr     = '0;
    out_data     = '0;
    case (state)
      IDLE:  if (start) state_nx = CLEAR;
      CLEAR: begin
        neuron_clear = 1'b1;
        state_nx     = ACCUM;
      end
      ACCUM: begin
        in_addr = idx;
        w_addr  = W_AW'(int'(tile) * N_IN + int'(idx));
        if (idx_last) state_nx = DRAIN;
      end
      DRAIN: state_nx = WRITE;
      WRITE: begin
        out_we   = 1'b1;
        out_addr = OUT_AW'(int'(tile) * N_PAR + int'(k));
        // accum is stable here: neuron_en dropped after DRAIN
        out_data = lane_relu[k];
        if (k_last) state_nx = tile_last ? FIN : CLEAR;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // neuron_en is the registered "address issued" flag, matching read latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= 1'b0;
      neuron_en <= 1'b0;
      idx       <= '0;
      tile      <= '0;
      k         <= '0;
    end else begin
      neuron_en <= (state == ACCUM);
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          tile <= '0;
        end
        CLEAR: idx <= '0;
        ACCUM: idx <= idx + 1'b1;
        DRAIN: k   <= '0;
        WRITE: begin
          k <= k + 1'b1;
          if (k_last && !tile_last) tile <= tile + 1'b1;
        end
        FIN:   busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_forprop_layer_ctrl.sv
// Directed bench: cycle traces of the layer sequencer for two sizings.
module tb_forprop_layer_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // DUT1: N_IN=4, N_OUT=4, N_PAR=2
  logic        rst1, start1, busy1, done1, clr1, en1, we1;
  logic [1:0]  ia1;
  logic [2:0]  wa1;
  logic [1:0]  oa1;
  logic [7:0]  od1;
  logic [15:0] acc1;

  forprop_layer_ctrl #(.N_IN(4), .N_OUT(4), .N_PAR(2)) dut1 (
    .clk(clk), .reset(rst1), .start(start1), .busy(busy1), .done(done1),
    .in_addr(ia1), .w_addr(wa1), .neuron_clear(clr1), .neuron_en(en1),
    .accum(acc1), .out_we(we1), .out_addr(oa1), .out_data(od1)
  );

  // DUT2: N_IN=1, N_OUT=2, N_PAR=2
  logic        rst2, start2, busy2, done2, clr2, en2, we2;
  logic [0:0]  ia2;
  logic [0:0]  wa2;
  logic [0:0]  oa2;
  logic [7:0]  od2;
  logic [15:0] acc2;

  forprop_layer_ctrl #(.N_IN(1), .N_OUT(2), .N_PAR(2)) dut2 (
    .clk(clk), .reset(rst2), .start(start2), .busy(busy2), .done(done2),
    .in_addr(ia2), .w_addr(wa2), .neuron_clear(clr2), .neuron_en(en2),
    .accum(acc2), .out_we(we2), .out_addr(oa2), .out_data(od2)
  );

  logic [31:0] t_busy, t_clr, t_en, t_done, t_we;
  logic [7:0]  t_ia [32];
  logic [7:0]  t_wa [32];
  logic [7:0]  t_oa [32];
  logic [7:0]  t_od [32];

  // Pulse start, then sample cycle c (c=1 is the cycle after start was taken).
  task automatic run1(input int repulse_c, input int abort_c,
                      input logic [15:0] a0, input logic [15:0] a1);
    t_busy = '0; t_clr = '0; t_en = '0; t_done = '0; t_we = '0;
    @(negedge clk);
    start1 = 1'b1;
    for (int c = 1; c < 24; c++) begin
      @(negedge clk);
      start1 = (c == repulse_c);
      acc1   = (c < 9) ? a0 : a1;
      #1;
      t_busy[c] = busy1; t_clr[c] = clr1; t_en[c] = en1;
      t_done[c] = done1; t_we[c]  = we1;
      t_ia[c] = 8'(ia1); t_wa[c] = 8'(wa1); t_oa[c] = 8'(oa1); t_od[c] = od1;
      if (c == abort_c) begin
        #1 rst1 = 1'b0;
        #1;
        chk("abort_busy", busy1, 0);
        chk("abort_we", we1, 0);
        chk("abort_oaddr", oa1, 0);
        chk("abort_odata", od1, 0);
        chk("abort_en", en1, 0);
        chk("abort_waddr", wa1, 0);
      end
    end
  endtask

  task automatic chk_timing(input string tag);
    chk({tag, "_busy"}, t_busy, 32'h0003_FFFE);
    chk({tag, "_clr"},  t_clr,  32'h0000_0202);
    chk({tag, "_en"},   t_en,   32'h0000_7878);
    chk({tag, "_done"}, t_done, 32'h0002_0000);
    chk({tag, "_we"},   t_we,   32'h0001_8180);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_ia0"}, t_ia[2+i],  i);
      chk({tag, "_wa0"}, t_wa[2+i],  i);
      chk({tag, "_ia1"}, t_ia[10+i], i);
      chk({tag, "_wa1"}, t_wa[10+i], 4 + i);
    end
    chk({tag, "_ia_drain"}, t_ia[6], 0);
    chk({tag, "_oa0"}, t_oa[7],  0);
    chk({tag, "_oa1"}, t_oa[8],  1);
    chk({tag, "_oa2"}, t_oa[15], 2);
    chk({tag, "_oa3"}, t_oa[16], 3);
  endtask

  initial begin
    rst1 = 1'b0; rst2 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    acc1 = '0; acc2 = '0;
    #1;
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_en", en1, 0);
    chk("rst_clr", clr1, 0);
    chk("rst_addr", {ia1, wa1, oa1}, 0);
    chk("rst_od", od1, 0);
    repeat (3) @(negedge clk);
    rst1 = 1'b1; rst2 = 1'b1;
    @(negedge clk);

    // Tile0 writes relu(+1.0)=0x20, relu(-1.0)=0; tile1 0x7F passes, 0x00 stays
    run1(0, 0, 16'hE020, 16'h007F);
    chk_timing("a");
    chk("a_od0", t_od[7],  8'h20);
    chk("a_od1", t_od[8],  8'h00);
    chk("a_od2", t_od[15], 8'h7F);
    chk("a_od3", t_od[16], 8'h00);

    // Start re-pulsed in the 3rd ACCUM cycle must be ignored
    run1(4, 0, 16'h8001, 16'h7F80);
    chk_timing("b");
    chk("b_od0", t_od[7],  8'h01);
    chk("b_od1", t_od[8],  8'h00);
    chk("b_od2", t_od[15], 8'h00);
    chk("b_od3", t_od[16], 8'h7F);

    // Reset during tile 1 WRITE aborts with no done
    run1(0, 15, 16'h0010, 16'h0020);
    chk("c_done", t_done, 0);
    chk("c_we15", t_we[15], 1);
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    run1(0, 0, 16'h0000, 16'h0000);
    chk_timing("d");

    // Single-input layer: one ACCUM cycle, done 6 cycles after start
    t_busy = '0; t_en = '0; t_done = '0; t_we = '0;
    @(negedge clk);
    start2 = 1'b1;
    for (int c = 1; c < 12; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      acc2   = 16'h807F;
      #1;
      t_busy[c] = busy2; t_en[c] = en2; t_done[c] = done2; t_we[c] = we2;
      t_ia[c] = 8'(ia2); t_wa[c] = 8'(wa2); t_oa[c] = 8'(oa2); t_od[c] = od2;
    end
    chk("n1_busy", t_busy, 32'h0000_007E);
    chk("n1_en",   t_en,   32'h0000_0008);
    chk("n1_done", t_done, 32'h0000_0040);
    chk("n1_we",   t_we,   32'h0000_0030);
    chk("n1_oa0", t_oa[4], 0);
    chk("n1_od0", t_od[4], 8'h7F);
    chk("n1_oa1", t_oa[5], 1);
    chk("n1_od1", t_od[5], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
